// File: rtl/dma_desc_sched.sv
// Descriptor FIFO and sequencer for the DMA core: issues one descriptor at a time,
// waits for the completion pulse, counts completions and raises a sticky interrupt.
module dma_desc_sched #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [ADDR_W-1:0]          push_src_i,
    input  logic [ADDR_W-1:0]          push_dst_i,
    input  logic [DATA_W-1:0]          push_qty_i,
    input  logic                       push_irq_i,
    input  logic                       abort_i,
    output logic                       dma_en_o,
    output logic [ADDR_W-1:0]          dma_src_o,
    output logic [ADDR_W-1:0]          dma_dst_o,
    output logic [DATA_W-1:0]          dma_qty_o,
    input  logic                       dma_fin_i,
    output logic                       irq_o,
    input  logic                       irq_clr_i,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     fifo_cnt_o,
    output logic [CNT_W-1:0]           done_cnt_o,
    output logic [1:0]                 dbg_state_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SKIP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] src_mem [DEPTH];
    logic [ADDR_W-1:0] dst_mem [DEPTH];
    logic [DATA_W-1:0] qty_mem [DEPTH];
    logic              irq_mem [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;
    logic          irq_flag;

    // Push handshake: a descriptor transfers on the rising edge where push_valid_i
    // and push_ready_o are both high; ready drops when full or while abort_i is high.
    assign push_ready_o = (cnt != FULL_CNT) & ~abort_i;
    assign do_push      = push_valid_i & push_ready_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            src_mem[wr_ptr] <= push_src_i;
            dst_mem[wr_ptr] <= push_dst_i;
            qty_mem[wr_ptr] <= push_qty_i;
            irq_mem[wr_ptr] <= push_irq_i;
        end
    end

    // Abort empties the queue; a head popped in the same cycle is already latched below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (abort_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (cnt != '0) begin
                    do_pop    = 1'b1;
                    state_nxt = (qty_mem[rd_ptr] == '0) ? SKIP : ISSUE;
                end
            end
            ISSUE:   if (dma_fin_i) state_nxt = DONE;
            SKIP:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_src_o <= '0;
            dma_dst_o <= '0;
            dma_qty_o <= '0;
            irq_flag  <= 1'b0;
        end else if (do_pop) begin
            dma_src_o <= src_mem[rd_ptr];
            dma_dst_o <= dst_mem[rd_ptr];
            dma_qty_o <= qty_mem[rd_ptr];
            irq_flag  <= irq_mem[rd_ptr];
        end
    end

    // Setting the interrupt takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_cnt_o <= '0;
            irq_o      <= 1'b0;
        end else begin
            if (state == DONE) done_cnt_o <= done_cnt_o + CNT_W'(1);
            if (state == DONE && irq_flag) irq_o <= 1'b1;
            else if (irq_clr_i)            irq_o <= 1'b0;
        end
    end

    assign dma_en_o    = (state == ISSUE);
    assign busy_o      = (state != IDLE) | (cnt != '0);
    assign fifo_cnt_o  = cnt;
    assign dbg_state_o = state;

endmodule

// File: tb/tb_dma_desc_sched.sv
// Directed bench for dma_desc_sched: expected issues are queued at push time and
// compared when dma_en_o rises; counters, interrupt and reset behaviour checked inline.
module tb_dma_desc_sched;

    localparam int CW_TB = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             push_valid;
    logic             push_ready;
    logic [31:0]      push_src, push_dst, push_qty;
    logic             push_irq;
    logic             abort;
    logic             dma_en;
    logic [31:0]      dma_src, dma_dst, dma_qty;
    logic             dma_fin;
    logic             irq;
    logic             irq_clr;
    logic             busy;
    logic [2:0]       fifo_cnt;
    logic [CW_TB-1:0] done_cnt;
    logic [1:0]       dbg_state;

    int total = 0;
    int bad   = 0;
    int exp_done = 0;

    logic [95:0] exp_q[$];
    logic [95:0] cur_desc;
    logic        prev_en;
    int          low_run, hi_run, last_hi;

    dma_desc_sched #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .CNT_W(CW_TB)) dut (
        .clk(clk), .rst(rst),
        .push_valid_i(push_valid), .push_ready_o(push_ready),
        .push_src_i(push_src), .push_dst_i(push_dst), .push_qty_i(push_qty), .push_irq_i(push_irq),
        .abort_i(abort),
        .dma_en_o(dma_en), .dma_src_o(dma_src), .dma_dst_o(dma_dst), .dma_qty_o(dma_qty),
        .dma_fin_i(dma_fin),
        .irq_o(irq), .irq_clr_i(irq_clr),
        .busy_o(busy), .fifo_cnt_o(fifo_cnt), .done_cnt_o(done_cnt),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue monitor: order, stability while enabled, and low gap between transfers.
    always @(negedge clk) begin
        if (!rst) begin
            prev_en = 1'b0;
            low_run = 99;
            hi_run  = 0;
        end else begin
            if (dma_en && !prev_en) begin
                check("en_gap_ge2", low_run >= 2, 1'b1);
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", {dma_src, dma_dst, dma_qty}, 96'h0);
                    cur_desc = {dma_src, dma_dst, dma_qty};
                end else begin
                    cur_desc = exp_q.pop_front();
                    check("issue_desc", {dma_src, dma_dst, dma_qty}, cur_desc);
                end
                hi_run = 1;
            end else if (dma_en) begin
                check("dma_stable", {dma_src, dma_dst, dma_qty}, cur_desc);
                hi_run++;
            end else if (prev_en) begin
                last_hi = hi_run;
                low_run = 1;
            end else begin
                low_run++;
            end
            prev_en = dma_en;
        end
    end

    task automatic push_desc(input logic [31:0] s, input logic [31:0] d,
                             input logic [31:0] q, input logic f);
        int guard;
        guard = 0;
        @(negedge clk);
        push_src = s; push_dst = d; push_qty = q; push_irq = f; push_valid = 1'b1;
        #1;
        while (!push_ready && guard < 500) begin
            @(negedge clk); #1;
            guard++;
        end
        check("push_accept", push_ready, 1'b1);
        if (push_ready && q != 0) exp_q.push_back({s, d, q});
        @(posedge clk); #1;
        push_valid = 1'b0;
    endtask

    task automatic wait_en_high();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!dma_en && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("wait_en", dma_en, 1'b1);
    endtask

    task automatic fin_pulse();
        @(negedge clk);
        dma_fin = 1'b1;
        @(posedge clk); #1;
        dma_fin = 1'b0;
    endtask

    task automatic complete_one(input int hold);
        wait_en_high();
        repeat (hold - 1) @(negedge clk);
        dma_fin = 1'b1;
        @(posedge clk); #1;
        dma_fin = 1'b0;
        exp_done++;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_idle", busy, 1'b0);
    endtask

    initial begin
        rst = 1'b0; push_valid = 1'b0; push_src = '0; push_dst = '0; push_qty = '0;
        push_irq = 1'b0; abort = 1'b0; dma_fin = 1'b0; irq_clr = 1'b0;

        // Reset values
        #12;
        check("rst_ready", push_ready, 1'b1);
        check("rst_en", dma_en, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fifo_cnt", fifo_cnt, 3'd0);
        check("rst_done_cnt", done_cnt, 8'd0);
        check("rst_dma_src", dma_src, 32'd0);
        @(negedge clk); rst = 1'b1;

        // Single descriptor with 10-cycle hold
        push_desc(32'h1000, 32'h2000, 32'd8, 1'b1);
        check("single_cnt_after_push", fifo_cnt, 3'd1);
        check("single_en_after_push", dma_en, 1'b0);
        @(posedge clk); #1;
        check("single_en_after_pop", dma_en, 1'b1);
        check("single_cnt_after_pop", fifo_cnt, 3'd0);
        repeat (10) @(negedge clk);
        dma_fin = 1'b1;
        @(posedge clk); #1;
        dma_fin = 1'b0;
        exp_done++;
        check("single_en_drop", dma_en, 1'b0);
        check("single_done_before", done_cnt, 8'd0);
        @(posedge clk); #1;
        check("single_done", done_cnt, 8'(exp_done));
        check("single_irq", irq, 1'b1);
        check("single_busy", busy, 1'b0);
        check("single_hold_len", last_hi, 10);
        repeat (5) @(posedge clk); #1;
        check("single_irq_sticky", irq, 1'b1);
        @(negedge clk); irq_clr = 1'b1;
        @(posedge clk); #1; irq_clr = 1'b0;
        check("single_irq_clr", irq, 1'b0);

        // Fill: ready low at count 4, order preserved
        for (int i = 0; i < 5; i++)
            push_desc(32'h3000 + 32'(i) * 32'h10, 32'h4000 + 32'(i) * 32'h10, 32'd2 + 32'(i), 1'b0);
        check("fill_cnt_full", fifo_cnt, 3'd4);
        check("fill_ready_low", push_ready, 1'b0);
        @(negedge clk);
        push_src = 32'h3500; push_dst = 32'h4500; push_qty = 32'd7; push_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fill_refused", push_ready, 1'b0);
            @(negedge clk);
        end
        check("fill_cnt_hold", fifo_cnt, 3'd4);
        push_valid = 1'b0;
        complete_one(3);
        push_desc(32'h3500, 32'h4500, 32'd7, 1'b0);
        for (int i = 0; i < 5; i++) complete_one(2);
        wait_idle();
        check("fill_done", done_cnt, 8'(exp_done));
        check("fill_irq", irq, 1'b0);

        // Zero-length descriptor is skipped but counted
        push_desc(32'h5000, 32'h6000, 32'd0, 1'b1);
        push_desc(32'h5100, 32'h6100, 32'd4, 1'b0);
        exp_done++;
        begin
            int guard;
            guard = 0;
            while (done_cnt != 8'(exp_done) && guard < 50) begin
                @(negedge clk);
                guard++;
            end
        end
        check("skip_done", done_cnt, 8'(exp_done));
        check("skip_irq", irq, 1'b1);
        complete_one(4);
        wait_idle();
        check("skip_second_done", done_cnt, 8'(exp_done));
        check("skip_irq_kept", irq, 1'b1);
        @(negedge clk); irq_clr = 1'b1;
        @(posedge clk); #1; irq_clr = 1'b0;

        // Abort during first ISSUE with a concurrent push
        push_desc(32'h7000, 32'h8000, 32'd5, 1'b0);
        push_desc(32'h7100, 32'h8100, 32'd5, 1'b0);
        push_desc(32'h7200, 32'h8200, 32'd5, 1'b0);
        wait_en_high();
        @(negedge clk);
        abort = 1'b1; push_valid = 1'b1; push_src = 32'h7300; push_dst = 32'h8300; push_qty = 32'd3;
        #1;
        check("abort_ready_low", push_ready, 1'b0);
        @(posedge clk); #1;
        abort = 1'b0; push_valid = 1'b0;
        check("abort_cnt", fifo_cnt, 3'd0);
        check("abort_inflight_en", dma_en, 1'b1);
        exp_q.delete();
        fin_pulse();
        exp_done++;
        repeat (3) @(posedge clk); #1;
        check("abort_done", done_cnt, 8'(exp_done));
        check("abort_busy", busy, 1'b0);
        check("abort_en", dma_en, 1'b0);
        check("abort_cnt_after", fifo_cnt, 3'd0);

        // Races: irq set beats clear; spurious fin in IDLE
        push_desc(32'h9000, 32'hA000, 32'd3, 1'b1);
        wait_en_high();
        fin_pulse();
        exp_done++;
        irq_clr = 1'b1;
        @(posedge clk); #1;
        irq_clr = 1'b0;
        check("race_irq_set_wins", irq, 1'b1);
        @(negedge clk); irq_clr = 1'b1;
        @(posedge clk); #1; irq_clr = 1'b0;
        check("race_irq_cleared", irq, 1'b0);
        wait_idle();
        fin_pulse();
        repeat (2) @(posedge clk); #1;
        check("spurious_fin_cnt", done_cnt, 8'(exp_done));
        check("spurious_fin_irq", irq, 1'b0);
        check("spurious_fin_busy", busy, 1'b0);

        // done counter wrap
        while ((exp_done & 8'hFF) != 8'hFF) begin
            push_desc(32'hB000, 32'hC000, 32'd0, 1'b0);
            exp_done++;
        end
        wait_idle();
        check("wrap_max", done_cnt, 8'hFF);
        push_desc(32'hB000, 32'hC000, 32'd0, 1'b0);
        exp_done++;
        wait_idle();
        check("wrap_zero", done_cnt, 8'h00);

        // Asynchronous reset during ISSUE
        push_desc(32'hD000, 32'hE000, 32'd6, 1'b1);
        push_desc(32'hD100, 32'hE100, 32'd6, 1'b1);
        wait_en_high();
        #2;
        rst = 1'b0;
        #1;
        check("arst_en", dma_en, 1'b0);
        check("arst_cnt", fifo_cnt, 3'd0);
        check("arst_ready", push_ready, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_src", dma_src, 32'd0);
        exp_q.delete();
        exp_done = 0;
        @(negedge clk); rst = 1'b1;
        push_desc(32'hF000, 32'hF100, 32'd2, 1'b0);
        complete_one(2);
        wait_idle();
        check("arst_recover_done", done_cnt, 8'(exp_done));
        check("arst_exp_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
